// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal NIC: PE register map and status-word layout.
package cardinal_pkg;

   localparam logic [1:0] NIC_IN_DATA  = 2'b00;
   localparam logic [1:0] NIC_IN_STAT  = 2'b01;
   localparam logic [1:0] NIC_OUT_DATA = 2'b10;
   localparam logic [1:0] NIC_OUT_STAT = 2'b11;

   // Status bits are placed relative to the word MSB: flag at DATA_W-1,
   // occupancy field with its MSB at DATA_W-2, extending downward.
   localparam int STAT_FLAG_OFS = 1;
   localparam int STAT_CNT_OFS  = 2;

endpackage

// File: rtl/nic_fifo.sv
// Single-clock FIFO with registered occupancy; push refused when full, pop ignored when empty.
module nic_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DATA_W-1:0]            din,
   input  logic                         pop,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [DATA_W-1:0]            head
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Flags come from registered occupancy, so a same-cycle pop never frees room for a push.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; empty is decided by count alone,
   // and readers mask head when empty, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cardinal_nic_param.sv
// Network interface between a PE register port and a router: one input and one output channel FIFO.
module cardinal_nic_param
   import cardinal_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              nicEn,
   input  logic              nicWrEn,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_polarity
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic              in_full, in_empty, out_full, out_empty;
   logic [CNT_W-1:0]  in_count, out_count;
   logic [DATA_W-1:0] in_head, out_head;
   logic              pe_rd, in_push, in_pop, out_push, out_pop;

   assign pe_rd    = nicEn && !nicWrEn;
   assign net_ri   = !in_full;
   assign in_push  = net_si && net_ri;
   assign in_pop   = pe_rd && (addr == NIC_IN_DATA);
   assign out_push = nicEn && nicWrEn && (addr == NIC_OUT_DATA);
   // A packet only leaves in the virtual-channel phase that matches its bit 0.
   assign net_so   = !out_empty && (out_head[0] == net_polarity);
   assign out_pop  = net_so && net_ro;
   assign net_do   = out_empty ? '0 : out_head;

   nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_push),
      .din   (net_di),
      .pop   (in_pop),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count),
      .head  (in_head)
   );

   nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .din   (d_in),
      .pop   (out_pop),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count),
      .head  (out_head)
   );

   // NOTE: d_out is assigned a default before the decode so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      d_out = '0;
      if (pe_rd) begin
         case (addr)
            NIC_IN_DATA: if (!in_empty) d_out = in_head;
            NIC_IN_STAT: begin
               d_out[DATA_W-STAT_FLAG_OFS]        = !in_empty;
               d_out[DATA_W-STAT_CNT_OFS -: CNT_W] = in_count;
            end
            NIC_OUT_STAT: begin
               d_out[DATA_W-STAT_FLAG_OFS]        = out_full;
               d_out[DATA_W-STAT_CNT_OFS -: CNT_W] = out_count;
            end
            default: d_out = '0;
         endcase
      end
   end

endmodule
